gate_truth_tester: RTL



---
 rtl/gate_truth_tester.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/gate_truth_tester.sv
// Exhaustive truth-table checker for a single-output combinational gate: walks every input vector,
// samples the gate after a settle interval and compares it against a latched table. Optional: GATE_TRUTH_TESTER_LOG_EN.
module gate_truth_tester #(
    parameter int N_INPUTS = 2,
    parameter int SETTLE   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [(2**N_INPUTS)-1:0]   expected,
    input  logic                       dut_out,
    output logic [N_INPUTS-1:0]        dut_in,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [N_INPUTS:0]          err_count,
    output logic [N_INPUTS-1:0]        first_fail,
    output logic                       fail_valid
);

    localparam int NVEC = 2**N_INPUTS;
    localparam logic [N_INPUTS-1:0] VEC_LAST   = {N_INPUTS{1'b1}};
    localparam logic [N_INPUTS-1:0] VEC_ONE    = N_INPUTS'(1'b1);
    localparam logic [N_INPUTS:0]   ERR_ONE    = (N_INPUTS+1)'(1'b1);
    localparam logic [3:0]          SETTLE_CNT = 4'(SETTLE);
    localparam logic [3:0]          CNT_ONE    = 4'd1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [NVEC-1:0]       exp_r, exp_nxt_s;
    logic [N_INPUTS-1:0]   vec_r, vec_nxt_s;
    logic [3:0]            cnt_r, cnt_nxt_s;
    logic [N_INPUTS:0]     err_r, err_nxt_s, err_upd_s;
    logic [N_INPUTS-1:0]   ff_r, ff_nxt_s;
    logic                  fv_r, fv_nxt_s;
    logic                  pass_r, pass_nxt_s;
    logic                  busy_r, busy_nxt_s;
    logic                  done_r, done_nxt_s;
    logic                  mismatch_s;
    logic                  last_vec_s;

    assign mismatch_s = dut_out ^ exp_r[vec_r];
    assign last_vec_s = (vec_r == VEC_LAST);
    assign err_upd_s  = mismatch_s ? (err_r + ERR_ONE) : err_r;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_nxt_s = S_SETTLE;
                else       state_nxt_s = S_IDLE;
            end
            S_SETTLE: begin
                if (cnt_r == 4'd0) state_nxt_s = S_SAMPLE;
                else               state_nxt_s = S_SETTLE;
            end
            S_SAMPLE: begin
                if (last_vec_s) state_nxt_s = S_DONE;
                else            state_nxt_s = S_SETTLE;
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Next values of the registered datapath and outputs
    always_comb begin
        exp_nxt_s  = exp_r;
        vec_nxt_s  = vec_r;
        cnt_nxt_s  = cnt_r;
        err_nxt_s  = err_r;
        ff_nxt_s   = ff_r;
        fv_nxt_s   = fv_r;
        pass_nxt_s = pass_r;
        busy_nxt_s = busy_r;
        done_nxt_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    exp_nxt_s  = expected;
                    vec_nxt_s  = '0;
                    cnt_nxt_s  = SETTLE_CNT;
                    err_nxt_s  = '0;
                    ff_nxt_s   = '0;
                    fv_nxt_s   = 1'b0;
                    pass_nxt_s = 1'b0;
                    busy_nxt_s = 1'b1;
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            S_SETTLE: begin
                if (cnt_r != 4'd0) cnt_nxt_s = cnt_r - CNT_ONE;
                else               cnt_nxt_s = cnt_r;
            end
            S_SAMPLE: begin
                err_nxt_s = err_upd_s;
                if (mismatch_s && !fv_r) begin
                    ff_nxt_s = vec_r;
                    fv_nxt_s = 1'b1;
                end else begin
                    ff_nxt_s = ff_r;
                    fv_nxt_s = fv_r;
                end
                // Result is published on the same edge that enters DONE so done and pass line up.
                if (last_vec_s) begin
                    busy_nxt_s = 1'b0;
                    done_nxt_s = 1'b1;
                    pass_nxt_s = (err_upd_s == '0);
                end else begin
                    vec_nxt_s = vec_r + VEC_ONE;
                    cnt_nxt_s = SETTLE_CNT;
                end
            end
            S_DONE:  done_nxt_s = 1'b0;
            default: done_nxt_s = 1'b0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_r  <= '0;
            vec_r  <= '0;
            cnt_r  <= 4'd0;
            err_r  <= '0;
            ff_r   <= '0;
            fv_r   <= 1'b0;
            pass_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            exp_r  <= exp_nxt_s;
            vec_r  <= vec_nxt_s;
            cnt_r  <= cnt_nxt_s;
            err_r  <= err_nxt_s;
            ff_r   <= ff_nxt_s;
            fv_r   <= fv_nxt_s;
            pass_r <= pass_nxt_s;
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    assign dut_in     = vec_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign err_count  = err_r;
    assign first_fail = ff_r;
    assign fail_valid = fv_r;

`ifdef GATE_TRUTH_TESTER_LOG_EN
    // Simulation trace of each sampled vector and the final verdict
    always @(posedge clk) begin
        if (!reset && state_r == S_SAMPLE)
            $display("gate_truth_tester: vec=%0d dut_out=%b expected=%b", vec_r, dut_out, exp_r[vec_r]);
        if (!reset && state_r == S_DONE)
            $display("gate_truth_tester: %s err_count=%0d", pass_r ? "PASS" : "FAIL", err_r);
    end
`endif

endmodule
